// File: rtl/imem_loader.sv
// Framed byte-stream program loader: assembles 16-bit words (high byte first),
// writes them to sequential instruction memory addresses, verifies an XOR
// checksum and releases the core hold only after a clean frame.
module imem_loader #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [INSTR_W-1:0]  imem_wdata,
    output logic                core_hold,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     word_count
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
        S_WR   = 3'd4,
        S_CHK  = 3'd5,
        S_DONE = 3'd6,
        S_ERR  = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   remaining_q, remaining_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic [BYTE_W-1:0]   checksum_q, checksum_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [INSTR_W-1:0]  imem_wdata_q, imem_wdata_d;
    logic                core_hold_q, core_hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    word_count_q, word_count_d;
    logic                xfer;

    assign xfer = byte_valid & byte_ready;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: advance on byte transfers, WR always lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN;
            S_LEN:  if (xfer) state_d = S_HI;
            S_HI:   if (xfer) state_d = S_LO;
            S_LO:   if (xfer) state_d = S_WR;
            S_WR:   state_d = (remaining_q == '0) ? S_CHK : S_HI;
            S_CHK:  if (xfer) state_d = (byte_in == checksum_q) ? S_DONE : S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; byte_ready is a pure decode of state
    always_comb begin
        byte_ready   = 1'b0;
        remaining_d  = remaining_q;
        hi_d         = hi_q;
        checksum_d   = checksum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_hold_d  = core_hold_q;
        done_d       = done_q;
        err_d        = err_q;
        word_count_d = word_count_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    word_count_d = '0;
                    checksum_d   = '0;
                    core_hold_d  = 1'b1;
                    imem_addr_d  = '0;
                end
            end
            S_LEN: begin
                byte_ready = 1'b1;
                if (xfer) remaining_d = byte_in;
            end
            S_HI: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    hi_d       = byte_in;
                    checksum_d = checksum_q ^ byte_in;
                end
            end
            S_LO: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    checksum_d   = checksum_q ^ byte_in;
                    imem_wdata_d = INSTR_W'({hi_q, byte_in});
                    imem_we_d    = 1'b1;
                end
            end
            S_WR: begin
                word_count_d = word_count_q + CNT_W'(1);
                imem_addr_d  = imem_addr_q + ADDR_W'(1);
                if (remaining_q != '0) remaining_d = remaining_q - BYTE_W'(1);
            end
            S_CHK: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    if (byte_in == checksum_q) begin
                        done_d      = 1'b1;
                        core_hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            remaining_q  <= '0;
            hi_q         <= '0;
            checksum_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_hold_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
        end else begin
            remaining_q  <= remaining_d;
            hi_q         <= hi_d;
            checksum_q   <= checksum_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_hold_q  <= core_hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
            word_count_q <= word_count_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_hold  = core_hold_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are built from word lists, the
// expected memory writes are queued up front and a monitor pops them as the
// loader writes; end-of-frame status is checked against the frame's checksum.
module tb_imem_loader;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 16;

    logic                CLK = 1'b0;
    logic                RST_N = 1'b0;
    logic                start = 1'b0;
    logic [7:0]          byte_in = 8'h00;
    logic                byte_valid = 1'b0;
    logic                byte_ready;
    logic                imem_we;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INSTR_W-1:0]  imem_wdata;
    logic                core_hold;
    logic                done;
    logic                err;
    logic [ADDR_W:0]     word_count;

    imem_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    int          vectors = 0;
    int          miscompares = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [15:0] frame_words[$];
    logic [7:0]  stream[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every memory write must match the next queued expectation
    always @(negedge CLK) begin
        if (RST_N && imem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
                check("wr_data", 32'(imem_wdata), 32'(mon_e.data));
            end
            check("ready_low_during_write", 32'(byte_ready), 32'd0);
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_imem_we"},    32'(imem_we),    32'd0);
        check({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
        check({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
        check({tag, "_core_hold"},  32'(core_hold),  32'd1);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        byte_valid = 1'b0;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Offer one byte after `gap` idle cycles; returns just after the accepting edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge CLK);
            byte_valid = 1'b0;
        end
        @(negedge CLK);
        byte_in = b;
        byte_valid = 1'b1;
        n = 0;
        while (!byte_ready && n < 64) begin
            @(negedge CLK);
            n++;
        end
        if (!byte_ready) begin
            check("ready_timeout", 32'(byte_ready), 32'd1);
            byte_valid = 1'b0;
        end else begin
            @(posedge CLK);
        end
    endtask

    // Send frame_words as one frame; abort_idx >= 0 drops reset before that stream byte
    task automatic run_frame(input bit bad, input int gap_mode, input int start_idx,
                             input bit do_start, input int abort_idx);
        int         n;
        int         gap;
        logic [7:0] x;
        logic [7:0] hb;
        logic [7:0] lb;
        wr_t        e;
        n = frame_words.size();
        x = 8'h00;
        stream.delete();
        stream.push_back(8'(n - 1));
        for (int i = 0; i < n; i++) begin
            hb = frame_words[i][15:8];
            lb = frame_words[i][7:0];
            stream.push_back(hb);
            stream.push_back(lb);
            x = x ^ hb ^ lb;
            e.addr = 8'(i);
            e.data = frame_words[i];
            exp_q.push_back(e);
        end
        stream.push_back(bad ? (x ^ 8'h01) : x);
        if (do_start) pulse_start();
        for (int k = 0; k < stream.size(); k++) begin
            if (k == abort_idx) begin
                @(negedge CLK);
                byte_valid = 1'b0;
                #2 RST_N = 1'b0;
                #1 check_reset_values("abort");
                exp_q.delete();
                @(negedge CLK);
                RST_N = 1'b1;
                return;
            end
            if (k == start_idx) pulse_start();
            case (gap_mode)
                1:       gap = 1;
                2:       gap = int'($urandom_range(0, 3));
                default: gap = 0;
            endcase
            send_byte(stream[k], gap);
        end
        @(negedge CLK);
        byte_valid = 1'b0;
        check("end_done",       32'(done),       bad ? 32'd0 : 32'd1);
        check("end_err",        32'(err),        bad ? 32'd1 : 32'd0);
        check("end_core_hold",  32'(core_hold),  bad ? 32'd1 : 32'd0);
        check("end_word_count", 32'(word_count), 32'(n));
        check("end_imem_addr",  32'(imem_addr),  32'(n % 256));
        check("end_byte_ready", 32'(byte_ready), 32'd0);
        check("end_writes_all", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic load_basic();
        frame_words.delete();
        frame_words.push_back(16'h1234);
        frame_words.push_back(16'hABCD);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK);
        check_reset_values("reset");
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_no_ready", 32'(byte_ready), 32'd0);

        // Basic good frame, bad checksum, then gapped streams
        load_basic(); run_frame(1'b0, 0, -1, 1'b1, -1);
        load_basic(); run_frame(1'b1, 0, -1, 1'b1, -1);
        repeat (3) @(negedge CLK);
        check("err_sticky",     32'(err),        32'd1);
        check("err_ready_low",  32'(byte_ready), 32'd0);
        load_basic(); run_frame(1'b0, 1, -1, 1'b1, -1);
        load_basic(); run_frame(1'b0, 2, -1, 1'b1, -1);

        // Maximum frame: 256 words, address wraps to 0
        frame_words.delete();
        for (int i = 0; i < 256; i++) frame_words.push_back(16'(16'h1000 + i));
        run_frame(1'b0, 0, -1, 1'b1, -1);

        // Mid-frame reset after three payload bytes, then a fresh load
        load_basic(); run_frame(1'b0, 0, -1, 1'b1, 4);
        repeat (2) @(negedge CLK);
        check("post_abort_ready", 32'(byte_ready), 32'd0);
        load_basic(); run_frame(1'b0, 0, -1, 1'b1, -1);

        // start pulsed mid-payload is ignored
        frame_words.delete();
        for (int i = 0; i < 3; i++) frame_words.push_back(16'($urandom));
        run_frame(1'b0, 0, 3, 1'b1, -1);

        // start in DONE restarts into LEN
        pulse_start();
        check("restart_core_hold",  32'(core_hold),  32'd1);
        check("restart_done",       32'(done),       32'd0);
        check("restart_word_count", 32'(word_count), 32'd0);
        check("restart_ready",      32'(byte_ready), 32'd1);
        load_basic(); run_frame(1'b0, 2, -1, 1'b0, -1);

        // Random frames
        for (int r = 0; r < 8; r++) begin
            frame_words.delete();
            for (int i = 0; i < int'($urandom_range(1, 8)); i++)
                frame_words.push_back(16'($urandom));
            run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1, 1'b1, -1);
        end

        repeat (3) @(negedge CLK);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
